// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared definitions for the two-client RAM arbiter:
//   - arb_state_e : arbiter ownership states (IDLE, OWN0, OWN1)
//   - ADDR_W/DATA_W : default RAM geometry (1024 x 8)
//   - cnt_w()      : width of the burst counter for a given MAX_BURST
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  // Counter must hold 0..max_burst inclusive.
  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/ram_arb2_rsp.sv
// ram_arb2_rsp
// Read-return registers for the two arbiter clients. A granted read in the
// current cycle captures the RAM's async read data at the closing edge and
// raises that client's rvalid for exactly one cycle; rdata holds otherwise.
// Ports:
//   clk, rst     in   clock, synchronous active-high reset
//   rd0_i/rd1_i  in   client granted a read this cycle
//   dout_i       in   DATA_W  RAM async read data
//   rvalid0_o/rvalid1_o  out  registered read-valid pulses
//   rdata0_o/rdata1_o    out  DATA_W  registered read data
module ram_arb2_rsp
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = ram_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd0_i,
  input  logic              rd1_i,
  input  logic [DATA_W-1:0] dout_i,
  output logic              rvalid0_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata1_o
);

  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q,  rdata1_q;

  // Capture read data for whichever client was granted a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rd0_i;
      rvalid1_q <= rd1_i;
      if (rd0_i) begin
        rdata0_q <= dout_i;
      end
      if (rd1_i) begin
        rdata1_q <= dout_i;
      end
    end
  end

  assign rvalid0_o = rvalid0_q;
  assign rvalid1_o = rvalid1_q;
  assign rdata0_o  = rdata0_q;
  assign rdata1_o  = rdata1_q;

endmodule

// File: rtl/ram_asyn.sv
// ram_asyn
// Single-port RAM with synchronous write and asynchronous (combinational) read.
// Ports:
//   clk   in  write clock
//   addr  in  ADDR_W  read/write address
//   din   in  DATA_W  write data
//   w_en  in  write enable, write lands on the rising edge
//   dout  out DATA_W  read data for addr, combinational
// Contents are not reset.
module ram_asyn #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              w_en,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [1 << ADDR_W];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (w_en) begin
      mem_q[addr] <= din;
    end
  end

  assign dout = mem_q[addr];

endmodule

// File: rtl/ram_arb2.sv
// ram_arb2
// Two-client arbiter/sequencer in front of a single-port async-read RAM.
// Round-robin between clients with bounded burst ownership: an owner keeps
// the RAM while it requests, but yields after MAX_BURST consecutive accesses
// if the other client is waiting. The winner's address/data/write-enable are
// muxed onto the RAM; read data is registered back to the winner.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   reqN, weN, addrN, wdataN   client N request (held until gntN)
//   gntN                       client N accepted this cycle (combinational)
//   rvalidN, rdataN            client N registered read return
//   mem_addr/mem_din/mem_w_en  drive to RAM
//   mem_dout                   RAM async read data
module ram_arb2
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = ram_arb_pkg::ADDR_W,
  parameter int DATA_W    = ram_arb_pkg::DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_w_en,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int            CW      = cnt_w(MAX_BURST);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          last_q,  last_d;   // 1 = client 1 owned most recently

  logic sel0_s, sel1_s;

  // Winner selection: round-robin from IDLE, burst-bounded while owning.
  always_comb begin
    sel0_s = 1'b0;
    sel1_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          if (last_q) begin
            sel0_s = 1'b1;
          end else begin
            sel1_s = 1'b1;
          end
        end else if (req0) begin
          sel0_s = 1'b1;
        end else if (req1) begin
          sel1_s = 1'b1;
        end else begin
          sel0_s = 1'b0;
        end
      end
      OWN0: begin
        if (req0 && ((cnt_q < MAX_CNT) || !req1)) begin
          sel0_s = 1'b1;
        end else if (req1) begin
          sel1_s = 1'b1;
        end else begin
          sel0_s = 1'b0;
        end
      end
      OWN1: begin
        if (req1 && ((cnt_q < MAX_CNT) || !req0)) begin
          sel1_s = 1'b1;
        end else if (req0) begin
          sel0_s = 1'b1;
        end else begin
          sel1_s = 1'b0;
        end
      end
      default: begin
        sel0_s = 1'b0;
        sel1_s = 1'b0;
      end
    endcase
  end

  // Next-state, burst counter and last-owner update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (sel0_s) begin
      if (state_q == OWN0) begin
        cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + CNT_ONE;
      end else begin
        state_d = OWN0;
        cnt_d   = CNT_ONE;
        last_d  = 1'b0;
      end
    end else if (sel1_s) begin
      if (state_q == OWN1) begin
        cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + CNT_ONE;
      end else begin
        state_d = OWN1;
        cnt_d   = CNT_ONE;
        last_d  = 1'b1;
      end
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Grants and RAM mux; everything is forced idle while reset is held so a
  // write presented in the reset cycle never reaches the RAM.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    mem_w_en = 1'b0;
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (sel0_s) begin
      gnt0     = 1'b1;
      mem_addr = addr0;
      mem_din  = wdata0;
      mem_w_en = we0;
    end else if (sel1_s) begin
      gnt1     = 1'b1;
      mem_addr = addr1;
      mem_din  = wdata1;
      mem_w_en = we1;
    end else begin
      mem_w_en = 1'b0;
    end
  end

  ram_arb2_rsp #(
    .DATA_W (DATA_W)
  ) u_rsp (
    .clk       (clk),
    .rst       (rst),
    .rd0_i     (gnt0 & ~we0),
    .rd1_i     (gnt1 & ~we1),
    .dout_i    (mem_dout),
    .rvalid0_o (rvalid0),
    .rdata0_o  (rdata0),
    .rvalid1_o (rvalid1),
    .rdata1_o  (rdata1)
  );

endmodule

// File: tb/tb_ram_arb2.sv
// tb_ram_arb2
// Directed bench for ram_arb2 with ram_asyn behind it. Inputs change 1 ns
// after the rising edge; combinational outputs are sampled on the falling
// edge, registered outputs 1 ns after the rising edge.
module tb_ram_arb2;
  import ram_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [9:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic [9:0] mem_addr;
  logic [7:0] mem_din, mem_dout;
  logic       mem_w_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arb2 #(.ADDR_W(10), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_w_en(mem_w_en),
    .mem_dout(mem_dout)
  );

  ram_asyn #(.ADDR_W(10), .DATA_W(8)) u_ram (
    .clk(clk), .addr(mem_addr), .din(mem_din), .w_en(mem_w_en), .dout(mem_dout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = 10'd0; wdata0 = 8'd0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 10'd0; wdata1 = 8'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd5; wdata0 = 8'd66;
    req1 = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL reset_gnt got %b%b want 00", gnt0, gnt1);
    end
    checks++;
    if (mem_w_en !== 1'b0 || mem_addr !== 10'd0 || mem_din !== 8'd0) begin
      errors++; $display("FAIL reset_mem got w=%b a=%0d d=%0d want 0 0 0", mem_w_en, mem_addr, mem_din);
    end
    checks++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== 8'd0 || rdata1 !== 8'd0) begin
      errors++; $display("FAIL reset_rsp got v=%b%b d0=%0d d1=%0d want 00 0 0", rvalid0, rvalid1, rdata0, rdata1);
    end
    step();
    rst = 1'b0;
    idle_inputs();
    checks++;
    if (dut.state_q !== IDLE || dut.cnt_q !== 3'd0 || dut.last_q !== 1'b1) begin
      errors++; $display("FAIL reset_state got s=%0d c=%0d l=%b want 0 0 1", dut.state_q, dut.cnt_q, dut.last_q);
    end
  endtask

  task automatic test_single_client();
    logic [9:0] a [3];
    logic [7:0] d [3];
    a = '{10'd1010, 10'd1000, 10'd999};
    d = '{8'd210, 8'd110, 8'd255};
    for (int i = 0; i < 3; i++) begin
      req0 = 1'b1; we0 = 1'b1; addr0 = a[i]; wdata0 = d[i];
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_w_en !== 1'b1 || mem_addr !== a[i] || mem_din !== d[i]) begin
        errors++; $display("FAIL single_wr%0d got g=%b w=%b a=%0d d=%0d want 1 1 %0d %0d", i, gnt0, mem_w_en, mem_addr, mem_din, a[i], d[i]);
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      req0 = 1'b1; we0 = 1'b0; addr0 = a[i]; wdata0 = 8'd0;
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b1 || mem_w_en !== 1'b0) begin
        errors++; $display("FAIL single_rd_gnt%0d got g=%b w=%b want 1 0", i, gnt0, mem_w_en);
      end
      step();
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== d[i]) begin
        errors++; $display("FAIL single_rd%0d got v=%b d=%0d want 1 %0d", i, rvalid0, rdata0, d[i]);
      end
    end
    idle_inputs();
    step();
    checks++;
    if (rvalid0 !== 1'b0 || rdata0 !== 8'd255) begin
      errors++; $display("FAIL single_hold got v=%b d=%0d want 0 255", rvalid0, rdata0);
    end
  endtask

  task automatic test_tie_burst();
    logic exp0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd1010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd1000;
    for (int i = 0; i < 8; i++) begin
      exp0 = (i < 4);
      @(negedge clk);
      checks++;
      if (gnt0 !== exp0 || gnt1 !== !exp0) begin
        errors++; $display("FAIL burst_gnt%0d got %b%b want %b%b", i, gnt0, gnt1, exp0, !exp0);
      end
      step();
      checks++;
      if (rvalid0 !== exp0 || rvalid1 !== !exp0 || (exp0 && rdata0 !== 8'd210) || (!exp0 && rdata1 !== 8'd110)) begin
        errors++; $display("FAIL burst_rsp%0d got v=%b%b d0=%0d d1=%0d want %b%b 210/110", i, rvalid0, rvalid1, rdata0, rdata1, exp0, !exp0);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_contended_writes();
    // State is IDLE with client 1 last, so client 0 wins the tie.
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd888; wdata0 = 8'd144;
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'd666; wdata1 = 8'd9;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_w_en !== 1'b1 || mem_addr !== 10'd888 || mem_din !== 8'd144) begin
      errors++; $display("FAIL cont_wr0 got g=%b%b w=%b a=%0d d=%0d want 10 1 888 144", gnt0, gnt1, mem_w_en, mem_addr, mem_din);
    end
    step();
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b1 || mem_w_en !== 1'b1 || mem_addr !== 10'd666 || mem_din !== 8'd9) begin
      errors++; $display("FAIL cont_wr1 got g=%b%b w=%b a=%0d d=%0d want 01 1 666 9", gnt0, gnt1, mem_w_en, mem_addr, mem_din);
    end
    step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd666;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd888;
    @(negedge clk);
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_w_en !== 1'b0) begin
      errors++; $display("FAIL cont_rd1_gnt got g=%b%b w=%b want 01 0", gnt0, gnt1, mem_w_en);
    end
    step();
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== 8'd144 || rvalid0 !== 1'b0) begin
      errors++; $display("FAIL cont_rd1 got v=%b%b d1=%0d want 01 144", rvalid0, rvalid1, rdata1);
    end
    req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_w_en !== 1'b0) begin
      errors++; $display("FAIL cont_rd0_gnt got g=%b%b w=%b want 10 0", gnt0, gnt1, mem_w_en);
    end
    step();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'd9) begin
      errors++; $display("FAIL cont_rd0 got v=%b d0=%0d want 1 9", rvalid0, rdata0);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_early_release();
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd888;
    step();
    step();
    checks++;
    if (dut.state_q !== OWN1 || dut.cnt_q !== 3'd2) begin
      errors++; $display("FAIL early_setup got s=%0d c=%0d want 2 2", dut.state_q, dut.cnt_q);
    end
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd666;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL early_gnt got %b%b want 10", gnt0, gnt1);
    end
    step();
    checks++;
    if (dut.state_q !== OWN0 || dut.cnt_q !== 3'd1) begin
      errors++; $display("FAIL early_state got s=%0d c=%0d want 1 1", dut.state_q, dut.cnt_q);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_addr_extremes();
    logic [9:0] a [2];
    logic [7:0] d [2];
    a = '{10'd1023, 10'd0};
    d = '{8'd119, 8'd122};
    for (int i = 0; i < 2; i++) begin
      req0 = 1'b1; we0 = 1'b1; addr0 = a[i]; wdata0 = d[i];
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b1 || mem_addr !== a[i] || mem_w_en !== 1'b1) begin
        errors++; $display("FAIL ext_wr%0d got g=%b a=%0d w=%b want 1 %0d 1", i, gnt0, mem_addr, mem_w_en, a[i]);
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      req0 = 1'b1; we0 = 1'b0; addr0 = a[i];
      step();
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== d[i]) begin
        errors++; $display("FAIL ext_rd%0d got v=%b d=%0d want 1 %0d", i, rvalid0, rdata0, d[i]);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_burst();
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd555; wdata0 = 8'd77;
    step();
    idle_inputs();
    step();
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd550; wdata0 = 8'd5;
    step();
    addr0 = 10'd551; wdata0 = 8'd6;
    step();
    addr0 = 10'd555; wdata0 = 8'd10;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b0 || mem_w_en !== 1'b0) begin
      errors++; $display("FAIL rstmid_gate got g=%b w=%b want 0 0", gnt0, mem_w_en);
    end
    step();
    rst = 1'b0;
    checks++;
    if (dut.state_q !== IDLE || dut.cnt_q !== 3'd0 || rvalid0 !== 1'b0) begin
      errors++; $display("FAIL rstmid_state got s=%0d c=%0d v=%b want 0 0 0", dut.state_q, dut.cnt_q, rvalid0);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd555;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd550;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL rstmid_tie got %b%b want 10", gnt0, gnt1);
    end
    step();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'd77) begin
      errors++; $display("FAIL rstmid_read got v=%b d=%0d want 1 77", rvalid0, rdata0);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single_client();
    test_tie_burst();
    test_contended_writes();
    test_early_release();
    test_addr_extremes();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arb2.md
Name: ram_arb2

Overview:
- Two-client arbiter and sequencer for the single-port asynchronous-read RAM (ram_asyn, 1024x8).
- Grants the RAM to one requester per cycle, using round-robin with a bounded burst ownership.
- Muxes the winner's address, data and write-enable onto the RAM ports.
- Registers read data back to the winning client.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 8, RAM data width.
- MAX_BURST, 4, maximum consecutive accesses one owner may take while the other client is requesting; must be >= 1.

Ports:
- clk  in  1  single clock; RAM writes and all state update on the rising edge.
- rst  in  1  synchronous active-high reset.
- req0  in  1  client 0 access request; held until gnt0.
- we0  in  1  client 0 write (1) / read (0).
- addr0  in  ADDR_W  client 0 address.
- wdata0  in  DATA_W  client 0 write data.
- gnt0  out  1  client 0 access accepted this cycle (combinational).
- rvalid0  out  1  client 0 read data valid (registered).
- rdata0  out  DATA_W  client 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as client 0, for client 1.
- mem_addr  out  ADDR_W  to RAM addr.
- mem_din  out  DATA_W  to RAM din.
- mem_w_en  out  1  to RAM w_en.
- mem_dout  in  DATA_W  from RAM dout (async read).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE, cnt = 0, last = 1, so client 0 wins the first tie.
  - rvalid0/1 = 0, rdata0/1 = 0.
  - While rst = 1: gnt0/1 = 0, mem_w_en = 0, mem_addr = 0, mem_din = 0.
- FSM states: IDLE, OWN0, OWN1. cnt is a burst counter that saturates at MAX_BURST.
- Selection (combinational, each cycle):
  - IDLE, both requesting: select the client != last.
  - IDLE, one requesting: select that client.
  - OWNx, req_x=1 and (cnt < MAX_BURST or req_other=0): select x.
  - OWNx, otherwise, if req_other=1: select the other client.
  - No requests: nothing selected.
- Next state:
  - Selected x and already in OWNx: stay, cnt++ (saturating).
  - Selected x from another state: go to OWNx, cnt = 1, last = x.
  - Nothing selected: go to IDLE, cnt = 0; last is kept.
- Grant and RAM drive:
  - Exactly one gnt high when a client is selected, never both; gnt is 0 when nothing is selected.
  - Selected client's addr/wdata/we drive mem_addr/mem_din/mem_w_en.
  - With no grant, mem_w_en = 0 and mem_addr/mem_din = 0.
- Writes land in the RAM at the edge closing the grant cycle; no response is returned for a write.
- Read latency is 1 cycle:
  - On a granted read, rdata_x <= mem_dout and rvalid_x <= 1 at that edge.
  - rvalid_x is a single-cycle pulse per read; back-to-back reads give consecutive pulses.
  - rdata_x holds its value when rvalid_x = 0.
- Read-after-write, same address, same client: the next-cycle read returns the new data.
- Boundaries:
  - Address 1023 and address 0 pass through unmodified; no address wrap logic.
  - MAX_BURST = 1 gives strict alternation under contention.
  - A lone requester is served every cycle, indefinitely, with no bubble.
  - Owner drops req while the other is requesting: the other is granted in the same cycle.
- Reset mid-operation: state, counters and rvalid return to reset values on the next edge. The RAM contents are not cleared. A write presented in the reset cycle is not performed.

Decomposition:
- Package ram_arb_pkg holds:
  - the state enum {IDLE, OWN0, OWN1};
  - the default width constants ADDR_W = 10 and DATA_W = 8;
  - the count width function clog2(MAX_BURST+1).
- Sub-module ram_arb2_rsp: read-return register pair (rvalid/rdata per client). The FSM, selection and mux stay in ram_arb2.
- The bench instantiates ram_asyn behind ram_arb2.

Test Plan:
- Single client, writes then reads: client 0 writes 210@1010, 110@1000, 255@999, then reads the same addresses. Expect gnt0 every cycle and rvalid0 one cycle after each read, with rdata0 = 210, 110, 255.
- Simultaneous first request after reset: req0 and req1 both high, each doing a read. Expect gnt0 first. With MAX_BURST = 4, client 0 gets 4 grants, then client 1 gets 4; gnt0 and gnt1 are never high together.
- Contended writes then cross reads: client 0 writes 144@888 and client 1 writes 9@666, contended. Then client 0 reads 666 -> 9 and client 1 reads 888 -> 144. Check that mem_w_en is high only in write-grant cycles.
- Owner releases early: client 1 owns with cnt = 2 and drops req1 while req0 = 1. Expect gnt0 in the same cycle, state OWN0, cnt = 1.
- Address extremes: write 119@1023 and 122@0, then read both. Expect rdata = 119 and 122, with no aliasing.
- Reset mid-burst: rst is asserted for 1 cycle during client 0's third write of a burst to 555 with data 10. That write is not performed; a later read of 555 returns the prior value. After rst the FSM is in IDLE, rvalid = 0, and client 0 again wins the next tie.
